instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches instruction words from memory, decodes the
// opcode, steers the external program counter (hold / advance / relative branch /
// absolute jump) and issues non-control instructions to the datapath through a
// valid/ready handshake.
// Optional feature: define INSTR_COUNT_EN to count decoded instructions on
// RetiredCount; without it RetiredCount is tied to zero and no counter exists.
module instruction_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic signed [15:0]     PcValue,
  output logic signed [15:0]     PcLoadValue,
  output logic                   PcLoadEnable,
  output logic signed [8:0]      PcOffset,
  output logic                   PcOffsetEnable,
  output logic [15:0]            MemAddr,
  output logic                   MemReq,
  input  logic                   MemReady,
  input  logic [15:0]            MemData,
  input  logic                   ZeroFlag,
  input  logic                   Resume,
  output logic [15:0]            Instr,
  output logic                   InstrValid,
  input  logic                   InstrReady,
  output logic [COUNT_WIDTH-1:0] RetiredCount
);

  typedef enum logic [2:0] {
    START,
    FETCH,
    DECODE,
    FETCH_IMM,
    ISSUE,
    HALTED
  } stateType;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_BR   = 4'h1;
  localparam logic [3:0] OP_BRZ  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  stateType    state;
  stateType    nextState;
  logic [15:0] ir;
  logic        captureIr;
  logic [3:0]  opcode;

  assign opcode = ir[15:12];

  // State register; reset aborts whatever is in flight and restarts at START.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= START;
    end else begin
      state <= nextState;
    end
  end

  // Instruction register, loaded with the fetched word when the memory answers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ir <= '0;
    end else if (captureIr) begin
      ir <= MemData;
    end
  end

  // Next-state and output decode; the PC is held (offset 0) unless a state asks otherwise.
  always_comb begin
    nextState      = state;
    captureIr      = 1'b0;
    PcLoadValue    = '0;
    PcLoadEnable   = 1'b0;
    PcOffset       = '0;
    PcOffsetEnable = 1'b1;
    MemAddr        = PcValue;
    MemReq         = 1'b0;
    Instr          = '0;
    InstrValid     = 1'b0;
    case (state)
      START: begin
        nextState = FETCH;
      end
      FETCH: begin
        MemReq = 1'b1;
        if (MemReady) begin
          PcOffsetEnable = 1'b0;
          captureIr      = 1'b1;
          nextState      = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_NOP: begin
            nextState = FETCH;
          end
          OP_BR: begin
            PcOffset  = ir[8:0];
            nextState = FETCH;
          end
          OP_BRZ: begin
            if (ZeroFlag) begin
              PcOffset = ir[8:0];
            end
            nextState = FETCH;
          end
          OP_JMP: begin
            nextState = FETCH_IMM;
          end
          OP_HALT: begin
            nextState = HALTED;
          end
          default: begin
            nextState = ISSUE;
          end
        endcase
      end
      FETCH_IMM: begin
        MemReq = 1'b1;
        if (MemReady) begin
          PcOffsetEnable = 1'b0;
          PcLoadEnable   = 1'b1;
          PcLoadValue    = MemData;
          nextState      = FETCH;
        end
      end
      ISSUE: begin
        InstrValid = 1'b1;
        Instr      = ir;
        if (InstrReady) begin
          nextState = FETCH;
        end
      end
      HALTED: begin
        if (Resume) begin
          nextState = FETCH;
        end
      end
      default: begin
        nextState = START;
      end
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [COUNT_WIDTH-1:0] retired;

  // Count one instruction per decode cycle, wrapping naturally at the counter width.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      retired <= '0;
    end else if (state == DECODE) begin
      retired <= retired + COUNT_WIDTH'(1);
    end
  end

  assign RetiredCount = retired;
`else
  assign RetiredCount = '0;
`endif

endmodule
